// File: rtl/sm_trace_pkg.sv
// Shared definitions for the schoolMIPS trace buffer: capture FSM state
// encodings and the bit offsets of each field inside a trace entry.
package sm_trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_e;

  // Entry layout is {pc, instr, wdata}, with pc in the MSBs.
  function automatic int tr_pc_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int tr_instr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int tr_wdata_lsb(input int data_w);
    return 0 * data_w;
  endfunction

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace storage: one synchronous write port and one
// registered, enable-gated read port that holds its value between reads.
module sm_trace_ram #(
  parameter int W     = 96,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; readers mask
  // stale contents using the valid-entry count instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    // Same-address read during a write returns the old word.
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sm_trace_buffer.sv
// Instruction trace buffer beside sm_cpu: records {pc, instr, wdata} per
// retired instruction into a circular RAM with trigger, post-count and watchdog.
module sm_trace_buffer
  import sm_trace_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 120,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_valid,
  input  logic [DATA_W-1:0]   cpu_pc,
  input  logic [DATA_W-1:0]   cpu_instr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_wrap,
  input  logic                cfg_trig_en,
  input  logic [DATA_W-1:0]   cfg_trig_pc,
  input  logic [AW-1:0]       cfg_post,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_idx,
  output logic [3*DATA_W-1:0] rd_data,
  output logic [AW:0]         count,
  output logic                busy,
  output logic                done,
  output logic                trig_seen,
  output logic                timeout
);

  localparam int EW     = 3 * DATA_W;
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PC_LSB = tr_pc_lsb(DATA_W);
  localparam int IN_LSB = tr_instr_lsb(DATA_W);
  localparam int WD_LSB = tr_wdata_lsb(DATA_W);

  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  tr_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] post_left_q, post_left_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          trig_seen_q, trig_seen_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_zero_q, rd_zero_d;

  logic          wr_en;
  logic          trig_hit;
  logic [EW-1:0] wr_entry;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] ram_rdata;

  always_comb begin
    wr_entry = '0;
    wr_entry[PC_LSB +: DATA_W] = cpu_pc;
    wr_entry[IN_LSB +: DATA_W] = cpu_instr;
    wr_entry[WD_LSB +: DATA_W] = cpu_wdata;
  end

  assign trig_hit = cfg_trig_en && cpu_valid && (cpu_pc == cfg_trig_pc);

  // With a full buffer count's low bits are zero, so the oldest entry is wr_ptr.
  assign rd_addr = wr_ptr_q - count_q[AW-1:0] + rd_idx;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_left_d = post_left_q;
    cyc_d       = cyc_q;
    trig_seen_d = trig_seen_q;
    timeout_d   = timeout_q;
    wr_en       = 1'b0;

    if (start) begin
      state_d     = TR_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      cyc_d       = '0;
      trig_seen_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (state_q == TR_ARMED || state_q == TR_POST) begin
      if (stop) begin
        state_d = TR_DONE;
      end else begin
        cyc_d = cyc_q + 1'b1;
        if (cpu_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != COUNT_FULL) count_d = count_q + 1'b1;

          if (state_q == TR_ARMED) begin
            if (trig_hit) trig_seen_d = 1'b1;
            // A fill-to-full in stop-when-full mode beats a simultaneous trigger.
            if (!cfg_wrap && count_q == COUNT_LAST) begin
              state_d = TR_DONE;
            end else if (trig_hit) begin
              post_left_d = cfg_post;
              state_d     = (cfg_post == '0) ? TR_DONE : TR_POST;
            end
          end else begin
            post_left_d = post_left_q - 1'b1;
            if (post_left_q == AW'(1)) state_d = TR_DONE;
          end
        end

        if (TIMEOUT != 0 && cyc_q == CYC_LAST) begin
          state_d   = TR_DONE;
          timeout_d = 1'b1;
        end
      end
    end

    busy_d    = (state_d == TR_ARMED) || (state_d == TR_POST);
    done_d    = (state_d == TR_DONE);
    rd_zero_d = rd_en ? ({1'b0, rd_idx} >= count_q) : rd_zero_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TR_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_left_q <= '0;
      cyc_q       <= '0;
      trig_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_left_q <= post_left_d;
      cyc_q       <= cyc_d;
      trig_seen_q <= trig_seen_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  sm_trace_ram #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Out-of-range reads and the unwritten RAM after reset both read as zero.
  assign rd_data   = rd_zero_q ? '0 : ram_rdata;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_seen = trig_seen_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer at DEPTH=8: fill, wrap, trigger,
// watchdog, async reset mid-capture and start/stop collision.
module tb_sm_trace_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid;
  logic [DW-1:0] cpu_pc, cpu_instr, cpu_wdata;
  logic          start, stop, cfg_wrap, cfg_trig_en;
  logic [DW-1:0] cfg_trig_pc;
  logic [AW-1:0] cfg_post;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [3*DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          busy, done, trig_seen, timeout;

  int checks = 0;
  int errors = 0;

  sm_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(120)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_pc(cpu_pc),
    .cpu_instr(cpu_instr), .cpu_wdata(cpu_wdata), .start(start), .stop(stop),
    .cfg_wrap(cfg_wrap), .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
    .cfg_post(cfg_post), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .count(count), .busy(busy), .done(done), .trig_seen(trig_seen),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [3*DW-1:0] ent(input logic [DW-1:0] p);
    return {p, 32'hA500_0000 | p, p * 3 + 32'h100};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] p);
    cpu_valid = 1'b1;
    cpu_pc    = p;
    cpu_instr = 32'hA500_0000 | p;
    cpu_wdata = p * 3 + 32'h100;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic read(input int idx, output logic [3*DW-1:0] d);
    rd_en  = 1'b1;
    rd_idx = AW'(idx);
    tick();
    rd_en  = 1'b0;
    d      = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({count, busy, done, trig_seen, timeout} !== 8'h00 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d b=%b d=%b t=%b to=%b rd=%h want all zero",
               count, busy, done, trig_seen, timeout, rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_nowrap();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
    do_start();
    checks++;
    if (busy !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL fill_armed got busy=%b cnt=%0d want busy=1 cnt=0", busy, count);
    end
    for (int p = 0; p < 5; p++) push(DW'(p));
    checks++;
    if (count !== 4'd5 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL fill_5 got cnt=%0d busy=%b done=%b want 5 1 0", count, busy, done);
    end
    for (int p = 5; p < 8; p++) push(DW'(p));
    checks++;
    if (count !== 4'd8 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL fill_full got cnt=%0d done=%b busy=%b want 8 1 0", count, done, busy);
    end
    push(32'd50);
    checks++;
    if (count !== 4'd8) begin
      errors++; $display("FAIL fill_done_ignores got cnt=%0d want 8", count);
    end
    read(0, d);
    checks++;
    if (d !== ent(32'd0)) begin
      errors++; $display("FAIL fill_rd0 got %h want %h", d, ent(32'd0));
    end
    read(7, d);
    checks++;
    if (d !== ent(32'd7)) begin
      errors++; $display("FAIL fill_rd7 got %h want %h", d, ent(32'd7));
    end
  endtask

  task automatic test_wrap_stop();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b1; cfg_trig_en = 1'b0;
    do_start();
    for (int p = 0; p < 20; p++) push(DW'(p));
    stop = 1'b1;
    push(32'd99);
    stop = 1'b0;
    checks++;
    if (count !== 4'd8 || done !== 1'b1) begin
      errors++; $display("FAIL wrap_stop got cnt=%0d done=%b want 8 1", count, done);
    end
    for (int i = 0; i < 8; i++) begin
      read(i, d);
      checks++;
      if (d !== ent(DW'(12 + i))) begin
        errors++; $display("FAIL wrap_rd%0d got %h want %h", i, d, ent(DW'(12 + i)));
      end
    end
  endtask

  task automatic test_trigger_post();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b1; cfg_trig_en = 1'b1; cfg_trig_pc = 32'd10; cfg_post = 3'd3;
    do_start();
    for (int p = 0; p < 20; p++) begin
      push(DW'(p));
      if (p == 12) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || trig_seen !== 1'b1) begin
          errors++; $display("FAIL trig_pc12 got busy=%b done=%b ts=%b want 1 0 1", busy, done, trig_seen);
        end
      end
      if (p == 13) begin
        checks++;
        if (done !== 1'b1 || trig_seen !== 1'b1 || timeout !== 1'b0) begin
          errors++; $display("FAIL trig_pc13 got done=%b ts=%b to=%b want 1 1 0", done, trig_seen, timeout);
        end
      end
    end
    read(7, d);
    checks++;
    if (d !== ent(32'd13)) begin
      errors++; $display("FAIL trig_last got %h want %h", d, ent(32'd13));
    end
    read(0, d);
    checks++;
    if (d !== ent(32'd6) || count !== 4'd8) begin
      errors++; $display("FAIL trig_first got %h cnt=%0d want %h cnt=8", d, count, ent(32'd6));
    end
  endtask

  task automatic test_timeout();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b1; cfg_trig_en = 1'b0;
    do_start();
    repeat (119) tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early got done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL timeout_fire got done=%b to=%b cnt=%0d want 1 1 0", done, timeout, count);
    end
    read(0, d);
    checks++;
    if (d !== '0) begin
      errors++; $display("FAIL timeout_rd0 got %h want 0", d);
    end
    read(5, d);
    checks++;
    if (d !== '0) begin
      errors++; $display("FAIL timeout_rd5 got %h want 0", d);
    end
  endtask

  task automatic test_async_reset();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b1; cfg_trig_en = 1'b1; cfg_trig_pc = 32'd10; cfg_post = 3'd3;
    do_start();
    for (int p = 0; p <= 10; p++) push(DW'(p));
    checks++;
    if (busy !== 1'b1 || trig_seen !== 1'b1) begin
      errors++; $display("FAIL arst_post got busy=%b ts=%b want 1 1", busy, trig_seen);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, busy, done, trig_seen, timeout} !== 8'h00 || rd_data !== '0) begin
      errors++; $display("FAIL arst_outputs got cnt=%0d b=%b d=%b ts=%b to=%b rd=%h want all zero",
                         count, busy, done, trig_seen, timeout, rd_data);
    end
    rst = 1'b0;
    tick();
    cfg_trig_en = 1'b0;
    do_start();
    push(32'h40);
    push(32'h41);
    checks++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL arst_restart got cnt=%0d busy=%b want 2 1", count, busy);
    end
    read(0, d);
    checks++;
    if (d !== ent(32'h40)) begin
      errors++; $display("FAIL arst_rd0 got %h want %h", d, ent(32'h40));
    end
    read(1, d);
    checks++;
    if (d !== ent(32'h41)) begin
      errors++; $display("FAIL arst_rd1 got %h want %h", d, ent(32'h41));
    end
  endtask

  task automatic test_start_stop();
    logic [3*DW-1:0] d;
    cfg_wrap = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 32'd10; cfg_post = 3'd0;
    do_start();
    push(32'd3);
    push(32'd10);
    checks++;
    if (done !== 1'b1 || trig_seen !== 1'b1 || count !== 4'd2) begin
      errors++; $display("FAIL post0_done got done=%b ts=%b cnt=%0d want 1 1 2", done, trig_seen, count);
    end
    cfg_trig_en = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || trig_seen !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL startstop got busy=%b done=%b ts=%b cnt=%0d want 1 0 0 0",
                         busy, done, trig_seen, count);
    end
    push(32'h77);
    read(1, d);
    checks++;
    if (d !== '0) begin
      errors++; $display("FAIL startstop_rd_oob got %h want 0", d);
    end
    read(0, d);
    checks++;
    if (d !== ent(32'h77)) begin
      errors++; $display("FAIL startstop_rd0 got %h want %h", d, ent(32'h77));
    end
  endtask

  initial begin
    rst = 1'b1; cpu_valid = 1'b0; cpu_pc = '0; cpu_instr = '0; cpu_wdata = '0;
    start = 1'b0; stop = 1'b0; cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
    cfg_trig_pc = '0; cfg_post = '0; rd_en = 1'b0; rd_idx = '0;
    test_reset();
    test_fill_nowrap();
    test_wrap_stop();
    test_trigger_post();
    test_timeout();
    test_async_reset();
    test_start_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

On-chip instruction trace buffer for the schoolMIPS core: captures one `{pc, instr, wdata}` entry per retired instruction into a circular RAM, with PC-match trigger, post-trigger count and cycle-timeout watchdog. It is the synthesizable successor of the bench's per-cycle trace print and `Ncycle` timeout. It sits beside `sm_cpu`, fed from its PC/instruction/register-file observation signals, and is read back by a debug host or bench after capture stops.

## Interface

- `DATA_W`, 32: width of pc, instr and wdata fields.
- `DEPTH`, 64: entries; power of 2, ≥ 2. `AW` = log2(DEPTH) is a localparam.
- `TIMEOUT`, 120: capture-cycle limit; 0 disables the watchdog.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_valid`  in  1  one instruction retired this cycle.
- `cpu_pc`  in  DATA_W  word PC of that instruction.
- `cpu_instr`  in  DATA_W  instruction word.
- `cpu_wdata`  in  DATA_W  watched register value (e.g. `$v0`).
- `start`  in  1  pulse: clear and arm.
- `stop`  in  1  pulse: end capture.
- `cfg_wrap`  in  1  1 = overwrite oldest when full; 0 = stop when full.
- `cfg_trig_en`  in  1  enable PC-match trigger.
- `cfg_trig_pc`  in  DATA_W  trigger PC.
- `cfg_post`  in  AW  entries to capture after the trigger entry.
- `rd_en`  in  1  read request.
- `rd_idx`  in  AW  logical index; 0 = oldest entry.
- `rd_data`  out  3*DATA_W  `{pc, instr, wdata}`, pc in the MSBs.
- `count`  out  AW+1  valid entries, 0..DEPTH.
- `busy`  out  1  state is ARMED or POST.
- `done`  out  1  state is DONE.
- `trig_seen`  out  1  sticky; trigger fired.
- `timeout`  out  1  sticky; watchdog expired.

## Operation

- States: IDLE, ARMED, POST, DONE. Reset → IDLE. Every output resets to 0. RAM contents are not reset.
- `start` in any state → ARMED. It clears `wr_ptr`, `count`, `trig_seen`, `timeout` and the cycle counter. If `start` and `stop` are asserted in the same cycle, `start` wins.
- Write rule, ARMED/POST only:
  - `cpu_valid` writes the entry at `wr_ptr`.
  - `wr_ptr` = `wr_ptr`+1 mod DEPTH.
  - `count` saturates at DEPTH.
- ARMED transitions:
  - Trigger: `cfg_trig_en` && `cpu_valid` && `cpu_pc == cfg_trig_pc`. The trigger entry is written and `trig_seen` is set. Next state is POST with `post_left = cfg_post`, or DONE if `cfg_post == 0`.
  - `cfg_wrap = 0`: the write that makes `count == DEPTH` → DONE. If that write is also the trigger, DONE takes priority.
  - `cfg_wrap = 1`: capture continues until trigger, `stop` or timeout.
- POST:
  - Each write decrements `post_left`.
  - The write made with `post_left == 1` → DONE.
  - Writes always wrap here, regardless of `cfg_wrap`.
- `stop` in ARMED/POST → DONE. A `cpu_valid` in the same cycle is not written.
- Watchdog: the cycle counter increments every clock in ARMED/POST, whether or not `cpu_valid` is asserted. When the counter equals TIMEOUT−1 at an edge, the FSM goes to DONE and `timeout` is set. That edge's valid write still occurs.
- IDLE and DONE ignore `cpu_valid` and `stop`.
- Readout:
  - Physical address = (`wr_ptr` − `count` + `rd_idx`) mod DEPTH. When `count == DEPTH`, the oldest entry is at `wr_ptr`.
  - `rd_idx ≥ count` returns 0.
  - Reads are legal in any state. A read in the same cycle as a write to the same address returns the old data.
- Config inputs are sampled continuously and must be held stable while `busy`.

## Timing

- Capture: an entry written at edge N is readable via `rd_en` at edge N+1 or later.
- Read latency is 1 cycle: `rd_data` updates on the edge after `rd_en` and holds while `rd_en` = 0.
- `count`, `busy`, `done`, `trig_seen` and `timeout` are registered and reflect the edge just taken.
- `start` at edge N gives `busy = 1` after N. The first capturable instruction is at edge N+1.
- Async `rst` mid-capture: immediate IDLE, all outputs 0. A subsequent `start` is required.

## Structure

- Shared header `sm_trace.vh`, in the style of `sm_cpu.vh`:
  - state encodings `TR_IDLE`/`TR_ARMED`/`TR_POST`/`TR_DONE`;
  - entry field offsets `TR_PC_LSB`, `TR_INSTR_LSB`, `TR_WDATA_LSB`.
- Sub-module `sm_trace_ram`:
  - simple dual-port, DEPTH × 3*DATA_W;
  - one synchronous write port, one registered read port, no reset.
- FSM, pointers, counters and address arithmetic live in `sm_trace_buffer`.

## Test plan

- DEPTH=8, wrap=0, trigger off, 5 valids with pc 0..4 → `count`=5, `busy`. Then 3 more valids → `done`, `count`=8, `rd_idx`=0 returns pc 0.
- DEPTH=8, wrap=1, 20 valids with pc 0..19, then `stop` → `count`=8, `rd_idx` 0..7 returns pc 12..19. A valid issued in the `stop` cycle is not captured.
- Trigger at pc 10, `cfg_post`=3, wrap=1, pc 0..19 → `trig_seen`, `done` after the write of pc 13. The last entry is pc 13, and pc 14.. are ignored.
- TIMEOUT=120, `cpu_valid` held low after `start` → `done` and `timeout` after exactly 120 edges. `count`=0, all reads return 0.
- Async `rst` during POST → all outputs 0 immediately. A new `start` plus 2 valids gives `count`=2 and correct entries.
- `start`+`stop` in the same cycle from DONE → ARMED and sticky flags cleared. Read of `rd_idx` ≥ `count` → 0.
